// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_pkg
// Description : Shared types and constants for the writeback stage.
//               This package defines the load-size encoding, the writeback
//               FSM states and the datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN = 64;
    localparam int RD_W = 6;

    // Load funct3 encoding as delivered by the memory stage
    typedef enum logic [2:0] {
        LB     = 3'b000,
        LH     = 3'b001,
        LW     = 3'b010,
        LD     = 3'b011,
        LBU    = 3'b100,
        LHU    = 3'b101,
        LWU    = 3'b110,
        LD_ILL = 3'b111
    } ldsize_e;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        EXC = 1'b1
    } wb_state_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load extractor. Selects the byte, halfword,
//               word or doubleword addressed by the low address bits out of
//               the raw aligned doubleword, sign- or zero-extends it, and
//               flags misaligned accesses and the illegal size encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] i_data,
    input  logic [2:0]      i_a,
    input  logic [2:0]      i_ldsize,
    output logic [XLEN-1:0] o_value,
    output logic            o_bad
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_word;

    // Lane selection: the offset is the address scaled to the access size
    assign w_byte = i_data[{i_a, 3'b000} +: 8];
    assign w_half = i_data[{i_a[2:1], 4'b0000} +: 16];
    assign w_word = i_data[{i_a[2], 5'b00000} +: 32];

    // Extend the selected lane and check natural alignment for its size
    always_comb begin
        o_value = '0;
        o_bad   = 1'b0;
        case (i_ldsize)
            LB: begin
                o_value = {{(XLEN-8){w_byte[7]}}, w_byte};
            end
            LBU: begin
                o_value = {{(XLEN-8){1'b0}}, w_byte};
            end
            LH: begin
                o_value = {{(XLEN-16){w_half[15]}}, w_half};
                o_bad   = i_a[0];
            end
            LHU: begin
                o_value = {{(XLEN-16){1'b0}}, w_half};
                o_bad   = i_a[0];
            end
            LW: begin
                o_value = {{(XLEN-32){w_word[31]}}, w_word};
                o_bad   = |i_a[1:0];
            end
            LWU: begin
                o_value = {{(XLEN-32){1'b0}}, w_word};
                o_bad   = |i_a[1:0];
            end
            LD: begin
                o_value = i_data;
                o_bad   = |i_a;
            end
            default: begin
                o_value = '0;
                o_bad   = 1'b1;
            end
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage. Registers the MEM/WB bundle, extracts
//               load data, drives the register-file write port and the
//               WB->EX forwarding path, and traps misaligned/illegal loads
//               with a sticky exception held until exc_ack.
//               Optional feature macro: WB_RETIRE_CNT_EN enables the retired
//               instruction counter; otherwise instret is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import wb_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwb_ready,
    input  logic [XLEN-1:0]   memwb_aluresult,
    input  logic [XLEN-1:0]   memwb_loadeddata,
    input  logic [RD_W-1:0]   memwb_rd,
    input  logic              memwb_dataselect,
    input  logic [2:0]        memwb_ldsize,
    input  logic              memwb_regwrite,
    input  logic              exc_ack,
    output logic              rf_we,
    output logic [RD_W-1:0]   rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              WBEX_valid,
    output logic [RD_W-1:0]   WBEX_rd,
    output logic [XLEN-1:0]   WBEX_rdval,
    output logic              wb_exc,
    output logic [XLEN-1:0]   wb_badaddr,
    output logic [CNT_W-1:0]  instret
);

    // WB pipeline register
    logic              r_valid;
    logic [XLEN-1:0]   r_aluresult;
    logic [XLEN-1:0]   r_loadeddata;
    logic [RD_W-1:0]   r_rd;
    logic              r_dataselect;
    logic [2:0]        r_ldsize;
    logic              r_regwrite;

    wb_state_e         r_state;
    wb_state_e         w_state_next;
    logic [XLEN-1:0]   r_badaddr;

    logic [XLEN-1:0]   w_load_value;
    logic              w_align_bad;
    logic              w_bad;
    logic              w_trap;
    logic              w_capture;
    logic              w_wdata_sel;
    logic [XLEN-1:0]   w_wdata;

    load_align u_load_align (
        .i_data   (r_loadeddata),
        .i_a      (r_aluresult[2:0]),
        .i_ldsize (r_ldsize),
        .o_value  (w_load_value),
        .o_bad    (w_align_bad)
    );

    // ALU results are never faulting; only loads can trap
    assign w_bad       = r_dataselect & w_align_bad;
    assign w_trap      = r_valid & w_bad;
    // The edge that moves RUN->EXC must not accept a new bundle either
    assign w_capture   = (r_state == RUN) & ~w_trap;
    assign w_wdata_sel = r_dataselect;
    assign w_wdata     = w_wdata_sel ? w_load_value : r_aluresult;

    // MEM/WB register: load a bundle when accepting, otherwise insert a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_aluresult  <= '0;
            r_loadeddata <= '0;
            r_rd         <= '0;
            r_dataselect <= 1'b0;
            r_ldsize     <= 3'b000;
            r_regwrite   <= 1'b0;
        end else if (w_capture && memwb_ready) begin
            r_valid      <= 1'b1;
            r_aluresult  <= memwb_aluresult;
            r_loadeddata <= memwb_loadeddata;
            r_rd         <= memwb_rd;
            r_dataselect <= memwb_dataselect;
            r_ldsize     <= memwb_ldsize;
            r_regwrite   <= memwb_regwrite;
        end else begin
            r_valid      <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: trap on a faulting entry, leave on acknowledge
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_trap)  w_state_next = EXC;
            EXC:     if (exc_ack) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // Faulting address latched on the trapping edge and held while pending
    always_ff @(posedge clk) begin
        if (reset) begin
            r_badaddr <= '0;
        end else if (r_state == RUN && w_trap) begin
            r_badaddr <= r_aluresult;
        end
    end

    // Write port and forwarding; reset suppresses a write still in flight
    assign rf_we      = r_valid & r_regwrite & (r_rd != '0) & ~w_bad
                        & (r_state == RUN) & ~reset;
    assign rf_waddr   = r_rd;
    assign rf_wdata   = w_wdata;
    assign WBEX_valid = rf_we;
    assign WBEX_rd    = r_rd;
    assign WBEX_rdval = w_wdata;
    assign wb_exc     = (r_state == EXC);
    assign wb_badaddr = r_badaddr;

`ifdef WB_RETIRE_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_retire;
    logic [CNT_W-1:0] r_instret;

    // Stores and rd=0 writes still retire; faulting loads do not
    assign w_retire = r_valid & ~w_bad & (r_state == RUN);

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + c_cnt_one;
        end
    end

    assign instret = r_instret;
`else
    assign instret = {CNT_W{1'b0}};
`endif

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking bench for writeback_stage. Expected register
//               writes are queued when bundles are driven and popped when the
//               write port fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwb_ready;
    logic [63:0] memwb_aluresult;
    logic [63:0] memwb_loadeddata;
    logic [5:0]  memwb_rd;
    logic        memwb_dataselect;
    logic [2:0]  memwb_ldsize;
    logic        memwb_regwrite;
    logic        exc_ack;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        WBEX_valid;
    logic [5:0]  WBEX_rd;
    logic [63:0] WBEX_rdval;
    logic        wb_exc;
    logic [63:0] wb_badaddr;
    logic [63:0] instret;

    writeback_stage #(.CNT_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .memwb_ready      (memwb_ready),
        .memwb_aluresult  (memwb_aluresult),
        .memwb_loadeddata (memwb_loadeddata),
        .memwb_rd         (memwb_rd),
        .memwb_dataselect (memwb_dataselect),
        .memwb_ldsize     (memwb_ldsize),
        .memwb_regwrite   (memwb_regwrite),
        .exc_ack          (exc_ack),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .WBEX_valid       (WBEX_valid),
        .WBEX_rd          (WBEX_rd),
        .WBEX_rdval       (WBEX_rdval),
        .wb_exc           (wb_exc),
        .wb_badaddr       (wb_badaddr),
        .instret          (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  rd;
        logic [63:0] val;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_instret = 0;

    // Scoreboard: every write-port pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_waddr !== mon_e.rd || rf_wdata !== mon_e.val ||
                    WBEX_valid !== 1'b1 || WBEX_rd !== mon_e.rd || WBEX_rdval !== mon_e.val) begin
                    n_bad++;
                    $display("FAIL write_data: got rd=%0d data=%h fwd_v=%b fwd_rd=%0d fwd=%h, required rd=%0d data=%h",
                             rf_waddr, rf_wdata, WBEX_valid, WBEX_rd, WBEX_rdval, mon_e.rd, mon_e.val);
                end
            end
        end
    end

    function automatic logic [63:0] exp_ir();
`ifdef WB_RETIRE_CNT_EN
        return 64'(exp_instret);
`else
        return 64'd0;
`endif
    endfunction

    // Reference load extraction written as shift-then-mask
    function automatic logic [63:0] model_load(input logic [63:0] d, input logic [2:0] a, input logic [2:0] ls);
        logic [63:0] s;
        s = d >> (8 * int'(a));
        case (ls)
            3'd0:    return {{56{s[7]}}, s[7:0]};
            3'd1:    return {{48{s[15]}}, s[15:0]};
            3'd2:    return {{32{s[31]}}, s[31:0]};
            3'd4:    return s & 64'hFF;
            3'd5:    return s & 64'hFFFF;
            3'd6:    return s & 64'hFFFF_FFFF;
            default: return d;
        endcase
    endfunction

    task automatic push_wr(input logic [5:0] rd, input logic [63:0] val);
        wr_t w;
        w.rd  = rd;
        w.val = val;
        if (rd != 6'd0) exp_q.push_back(w);
    endtask

    task automatic drive(input logic rdy, input logic [63:0] alu, input logic [63:0] data,
                         input logic [5:0] rd, input logic dsel, input logic [2:0] ls, input logic rw);
        memwb_ready      = rdy;
        memwb_aluresult  = alu;
        memwb_loadeddata = data;
        memwb_rd         = rd;
        memwb_dataselect = dsel;
        memwb_ldsize     = ls;
        memwb_regwrite   = rw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        memwb_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        memwb_ready = 1'b0;
        exc_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_instret = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 6'd0 || rf_wdata !== 64'd0 || WBEX_valid !== 1'b0 ||
            WBEX_rd !== 6'd0 || WBEX_rdval !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_port: got we=%b addr=%0d data=%h fv=%b frd=%0d fval=%h, required all 0",
                     rf_we, rf_waddr, rf_wdata, WBEX_valid, WBEX_rd, WBEX_rdval);
        end
        n_cmp++;
        if (wb_exc !== 1'b0 || wb_badaddr !== 64'd0 || instret !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_status: got exc=%b bad=%h instret=%0d, required 0 0 0", wb_exc, wb_badaddr, instret);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ls;
        logic [2:0]  a;
        logic [63:0] d;
        logic [5:0]  rd;
        push_wr(6'd5, 64'hFFFF_FFFF_FFFF_FF80); exp_instret++;
        drive(1'b1, 64'h1003, 64'h0000_0000_8000_0000, 6'd5, 1'b1, 3'b000, 1'b1);
        push_wr(6'd6, 64'h0000_0000_0000_BEEF); exp_instret++;
        drive(1'b1, 64'h2006, 64'hBEEF_0000_0000_0000, 6'd6, 1'b1, 3'b101, 1'b1);
        push_wr(6'd7, 64'h0000_0000_8000_0001); exp_instret++;
        drive(1'b1, 64'h2004, 64'h8000_0001_1234_5678, 6'd7, 1'b1, 3'b110, 1'b1);
        for (int i = 0; i < 24; i++) begin
            ls = 3'($urandom_range(0, 6));
            a  = 3'($urandom_range(0, 7));
            a  = a & ~(3'((1 << ls[1:0]) - 1));
            d  = {$urandom, $urandom};
            rd = 6'($urandom_range(1, 63));
            push_wr(rd, model_load(d, a, ls)); exp_instret++;
            drive(1'b1, {32'h0, $urandom} & ~64'h7 | {61'd0, a}, d, rd, 1'b1, ls, 1'b1);
        end
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL loads_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_rd0_and_store();
        drive(1'b1, 64'h55, 64'h0, 6'd0, 1'b0, 3'b000, 1'b1); exp_instret++;
        n_cmp++;
        if (rf_we !== 1'b0 || WBEX_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rd0_write: got we=%b fv=%b, required 0 0", rf_we, WBEX_valid);
        end
        drive(1'b1, 64'h66, 64'h0, 6'd3, 1'b0, 3'b000, 1'b0); exp_instret++;
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL store_write: got we=%b, required 0", rf_we);
        end
        idle(1);
        n_cmp++;
        if (instret !== exp_ir()) begin
            n_bad++;
            $display("FAIL rd0_instret: got %0d, required %0d", instret, exp_ir());
        end
    endtask

    task automatic test_exception();
        drive(1'b1, 64'h1002, 64'h1111_2222_3333_4444, 6'd8, 1'b1, 3'b010, 1'b1);
        n_cmp++;
        if (rf_we !== 1'b0 || wb_exc !== 1'b0) begin
            n_bad++;
            $display("FAIL exc_present: got we=%b exc=%b, required 0 0", rf_we, wb_exc);
        end
        drive(1'b1, 64'h99, 64'h0, 6'd9, 1'b0, 3'b000, 1'b1);
        n_cmp++;
        if (wb_exc !== 1'b1 || wb_badaddr !== 64'h1002) begin
            n_bad++;
            $display("FAIL exc_raise: got exc=%b badaddr=%h, required 1 0000000000001002", wb_exc, wb_badaddr);
        end
        drive(1'b1, 64'h9A, 64'h0, 6'd9, 1'b0, 3'b000, 1'b1);
        drive(1'b1, 64'h9B, 64'h0, 6'd9, 1'b0, 3'b000, 1'b1);
        n_cmp++;
        if (wb_exc !== 1'b1 || wb_badaddr !== 64'h1002) begin
            n_bad++;
            $display("FAIL exc_sticky: got exc=%b badaddr=%h, required 1 0000000000001002", wb_exc, wb_badaddr);
        end
        exc_ack = 1'b1;
        drive(1'b1, 64'h9C, 64'h0, 6'd9, 1'b0, 3'b000, 1'b1);
        exc_ack = 1'b0;
        n_cmp++;
        if (wb_exc !== 1'b0) begin
            n_bad++;
            $display("FAIL exc_ack: got exc=%b, required 0", wb_exc);
        end
        push_wr(6'd10, 64'h77); exp_instret++;
        drive(1'b1, 64'h77, 64'h0, 6'd10, 1'b0, 3'b000, 1'b1);
        idle(1);
        n_cmp++;
        if (exp_q.size() != 0 || instret !== exp_ir()) begin
            n_bad++;
            $display("FAIL exc_resume: got outstanding=%0d instret=%0d, required 0 %0d", exp_q.size(), instret, exp_ir());
        end
    endtask

    task automatic test_bad_kinds();
        logic [63:0] addrs [5];
        logic [2:0]  sizes [5];
        addrs = '{64'h4001, 64'h4004, 64'h4000, 64'h4003, 64'h4006};
        sizes = '{3'b001, 3'b011, 3'b111, 3'b101, 3'b110};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, addrs[i], 64'hFFFF_FFFF_FFFF_FFFF, 6'd20, 1'b1, sizes[i], 1'b1);
            idle(1);
            n_cmp++;
            if (wb_exc !== 1'b1 || wb_badaddr !== addrs[i]) begin
                n_bad++;
                $display("FAIL bad_kind_%0d: got exc=%b badaddr=%h, required 1 %h", i, wb_exc, wb_badaddr, addrs[i]);
            end
            exc_ack = 1'b1;
            idle(1);
            exc_ack = 1'b0;
        end
        idle(1);
        n_cmp++;
        if (wb_exc !== 1'b0 || instret !== exp_ir()) begin
            n_bad++;
            $display("FAIL bad_kinds_end: got exc=%b instret=%0d, required 0 %0d", wb_exc, instret, exp_ir());
        end
    endtask

    task automatic test_ack_in_run();
        exc_ack = 1'b1;
        push_wr(6'd12, 64'hABCD); exp_instret++;
        drive(1'b1, 64'hABCD, 64'h0, 6'd12, 1'b0, 3'b000, 1'b1);
        exc_ack = 1'b0;
        idle(1);
        n_cmp++;
        if (wb_exc !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ack_in_run: got exc=%b outstanding=%0d, required 0 0", wb_exc, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push_wr(6'(i + 1), 64'(i) * 64'h111 + 64'h1); exp_instret++;
            drive(1'b1, 64'(i) * 64'h111 + 64'h1, 64'h0, 6'(i + 1), 1'b0, 3'b000, 1'b1);
            if (i == 4) idle(1);
        end
        idle(1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_writes: got %0d outstanding, required 0", exp_q.size());
        end
        n_cmp++;
        if (instret !== exp_ir()) begin
            n_bad++;
            $display("FAIL b2b_instret: got %0d, required %0d", instret, exp_ir());
        end
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 64'h3000, 64'hDEAD_BEEF_CAFE_F00D, 6'd11, 1'b1, 3'b011, 1'b1);
        reset       = 1'b1;
        memwb_ready = 1'b0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b0 || WBEX_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_inflight_we: got we=%b fv=%b, required 0 0", rf_we, WBEX_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_instret = 0;
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 6'd0 || rf_wdata !== 64'd0 || WBEX_rd !== 6'd0 ||
            WBEX_rdval !== 64'd0 || wb_exc !== 1'b0 || wb_badaddr !== 64'd0 || instret !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_inflight_out: got we=%b addr=%0d data=%h exc=%b bad=%h instret=%0d, required all 0",
                     rf_we, rf_waddr, rf_wdata, wb_exc, wb_badaddr, instret);
        end
        idle(2);
    endtask

    initial begin
        reset            = 1'b1;
        memwb_ready      = 1'b0;
        memwb_aluresult  = '0;
        memwb_loadeddata = '0;
        memwb_rd         = '0;
        memwb_dataselect = 1'b0;
        memwb_ldsize     = 3'b000;
        memwb_regwrite   = 1'b0;
        exc_ack          = 1'b0;
        test_reset();
        test_loads();
        test_rd0_and_store();
        test_exception();
        test_bad_kinds();
        test_ack_in_run();
        test_back_to_back();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire
